sram_master: RTL and testbench

- Initiator-side sequencer for the 36-bit SRAM command channel (cs_n / mosi / miso) of the 512K x 16 SRAM driver.
- Accepts 32-bit word read/write requests from the core-side memory stage and splits each into two 16-bit SRAM accesses: low halfword first, then high.
- Generates registered chip-select and command timing with programmable strobe width.
- Returns assembled read data with a one-cycle done pulse.

---
 rtl/sram_master.sv | 121 ++++++++++++
 tb/tb_sram_master.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_master.sv
// sram_master: splits 32-bit word requests into two
// 16-bit SRAM driver accesses with timed chip select.
module sram_master #(
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic        sck,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [17:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        cs_n,
  output logic [35:0] mosi,
  input  logic [15:0] miso
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO_SETUP,
    S_LO_ACC,
    S_LO_HOLD,
    S_HI_SETUP,
    S_HI_ACC,
    S_HI_HOLD,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(WAIT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic [17:0]      addr_q;
  logic [15:0]      wdata_hi;
  logic [31:0]      rbuf;

  // Sequencer: drives registered cs_n/mosi and
  // assembles read data one halfword at a time.
  always_ff @(posedge sck or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_hi <= '0;
      rbuf     <= '0;
      rdata    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cs_n     <= 1'b1;
      mosi     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req) begin
            we_q     <= we;
            addr_q   <= addr;
            wdata_hi <= wdata[31:16];
            mosi     <= {we,
                         we ? wdata[15:0] : 16'h0,
                         addr, 1'b0};
            busy     <= 1'b1;
            state    <= S_LO_SETUP;
          end
        end
        S_LO_SETUP: begin
          cs_n  <= 1'b0;
          cnt   <= CNT_LOAD;
          state <= S_LO_ACC;
        end
        S_LO_ACC: begin
          if (cnt == '0) begin
            cs_n <= 1'b1;
            if (!we_q) rbuf[15:0] <= miso;
            state <= S_LO_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_LO_HOLD: begin
          mosi  <= {we_q,
                    we_q ? wdata_hi : 16'h0,
                    addr_q, 1'b1};
          state <= S_HI_SETUP;
        end
        S_HI_SETUP: begin
          cs_n  <= 1'b0;
          cnt   <= CNT_LOAD;
          state <= S_HI_ACC;
        end
        S_HI_ACC: begin
          if (cnt == '0) begin
            cs_n <= 1'b1;
            if (!we_q) rbuf[31:16] <= miso;
            state <= S_HI_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_HI_HOLD: begin
          mosi  <= '0;
          done  <= 1'b1;
          if (!we_q) rdata <= rbuf;
          state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_master.sv
// tb_sram_master: random word traffic on two instances
// (WAIT_CYCLES 2 and 1) against a timeline reference model.
module tb_sram_master;

  logic        sck;
  logic        rst;
  logic        we;
  logic [17:0] addr;
  logic [31:0] wdata;
  logic        req_v   [2];
  logic [31:0] rdata_v [2];
  logic        busy_v  [2];
  logic        done_v  [2];
  logic        cs_n_v  [2];
  logic [35:0] mosi_v  [2];
  logic [15:0] miso_v  [2];

  bit   [15:0] mem [2**19];
  logic [31:0] exp_rd [2];
  int          acc_cnt [2];
  bit          scramble;
  int          checks;
  int          errors;

  sram_master #(.WAIT_CYCLES(2), .CNT_W(4)) u_dut0 (
    .sck(sck), .rst(rst), .req(req_v[0]), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata_v[0]),
    .busy(busy_v[0]), .done(done_v[0]),
    .cs_n(cs_n_v[0]), .mosi(mosi_v[0]),
    .miso(miso_v[0])
  );

  sram_master #(.WAIT_CYCLES(1), .CNT_W(4)) u_dut1 (
    .sck(sck), .rst(rst), .req(req_v[1]), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata_v[1]),
    .busy(busy_v[1]), .done(done_v[1]),
    .cs_n(cs_n_v[1]), .mosi(mosi_v[1]),
    .miso(miso_v[1])
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

  function automatic int wait_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  // SRAM driver model: miso carries the array value only in
  // the final strobe cycle when scrambling, else noise.
  always @(negedge sck) begin
    for (int k = 0; k < 2; k++) begin
      logic [18:0] ha;
      bit          last;
      if (!cs_n_v[k]) acc_cnt[k]++;
      else acc_cnt[k] = 0;
      ha   = mosi_v[k][18:0];
      last = !cs_n_v[k] && acc_cnt[k] == wait_of(k);
      if (!cs_n_v[k] && (last || !scramble))
        miso_v[k] = mem[ha];
      else
        miso_v[k] = 16'($urandom);
      if (last && mosi_v[k][35])
        mem[ha] = mosi_v[k][34:19];
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input int k, input string tag);
    check({tag, " cs_n"}, 64'(cs_n_v[k]), 64'd1);
    check({tag, " mosi"}, 64'(mosi_v[k]), 64'd0);
    check({tag, " busy"}, 64'(busy_v[k]), 64'd0);
    check({tag, " done"}, 64'(done_v[k]), 64'd0);
    check({tag, " rdata"}, 64'(rdata_v[k]),
          64'(exp_rd[k]));
  endtask

  // One word transfer, entered and left at a falling edge.
  task automatic run_txn(input int k,
                         input logic w,
                         input logic [17:0] a,
                         input logic [31:0] d,
                         input bit hold);
    int          wc;
    int          last;
    bit          acc;
    logic [35:0] lo;
    logic [35:0] hi;
    logic [35:0] em;
    logic [31:0] rd;
    wc   = wait_of(k);
    last = 2 * wc + 5;
    lo   = {w, w ? d[15:0] : 16'h0, a, 1'b0};
    hi   = {w, w ? d[31:16] : 16'h0, a, 1'b1};
    rd   = {mem[{a, 1'b1}], mem[{a, 1'b0}]};
    req_v[k] = 1'b1;
    we       = w;
    addr     = a;
    wdata    = d;
    @(posedge sck);
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge sck);
      acc = (c >= 2 && c <= wc + 1) ||
            (c >= wc + 4 && c <= 2 * wc + 3);
      if (c >= last)       em = '0;
      else if (c <= wc + 2) em = lo;
      else                 em = hi;
      if (c == last && !w) exp_rd[k] = rd;
      check("cs_n", 64'(cs_n_v[k]), 64'(!acc));
      check("mosi", 64'(mosi_v[k]), 64'(em));
      check("done", 64'(done_v[k]), 64'(c == last));
      check("busy", 64'(busy_v[k]), 64'(c <= last));
      check("rdata", 64'(rdata_v[k]), 64'(exp_rd[k]));
      if (c <= last) begin
        req_v[k] = hold ? 1'b1 : 1'($urandom);
        we       = 1'($urandom);
        addr     = 18'($urandom);
        wdata    = $urandom;
      end
    end
    req_v[k] = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    scramble  = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    acc_cnt[0] = 0;
    acc_cnt[1] = 0;
    req_v[0]  = 1'b0;
    req_v[1]  = 1'b0;
    we        = 1'b0;
    addr      = '0;
    wdata     = '0;
    rst       = 1'b0;
    repeat (3) @(negedge sck);
    chk_idle(0, "rst0");
    chk_idle(1, "rst1");
    rst = 1'b1;
    @(negedge sck);
    chk_idle(0, "post_rst");

    req_v[0] = 1'b1;
    we       = 1'b1;
    addr     = 18'h00abc;
    wdata    = 32'hcafef00d;
    @(negedge sck);
    req_v[0] = 1'b0;
    @(negedge sck);
    check("abort pre cs_n", 64'(cs_n_v[0]), 64'd0);
    #2 rst = 1'b0;
    #1 chk_idle(0, "abort");
    @(negedge sck);
    rst = 1'b1;
    repeat (3) @(negedge sck);
    chk_idle(0, "abort idle");

    run_txn(0, 1'b1, 18'h00012, 32'hdeadbeef, 1'b0);
    check("wr lo mem", 64'(mem[19'h00024]), 64'h0beef);
    check("wr hi mem", 64'(mem[19'h00025]), 64'h0dead);
    mem[19'h00024] = 16'h5678;
    mem[19'h00025] = 16'h1234;
    run_txn(0, 1'b0, 18'h00012, 32'h0, 1'b0);
    check("rd word", 64'(rdata_v[0]), 64'h12345678);

    run_txn(0, 1'b1, 18'h01000, 32'h0badf00d, 1'b1);
    run_txn(0, 1'b0, 18'h01000, 32'hffffffff, 1'b1);
    run_txn(0, 1'b1, 18'h3ffff, 32'h89abcdef, 1'b1);
    run_txn(0, 1'b0, 18'h3ffff, 32'h0, 1'b1);
    check("b2b rd", 64'(exp_rd[0]), 64'h89abcdef);
    check("b2b rdata", 64'(rdata_v[0]), 64'h89abcdef);

    run_txn(1, 1'b1, 18'h00100, 32'h13579bdf, 1'b0);
    run_txn(1, 1'b0, 18'h00100, 32'h0, 1'b0);
    check("w1 rdata", 64'(rdata_v[1]), 64'h13579bdf);

    scramble = 1'b1;
    run_txn(0, 1'b0, 18'h00012, 32'h0, 1'b0);
    check("scr rdata", 64'(rdata_v[0]), 64'h12345678);
    for (int i = 0; i < 24; i++) begin
      int          k;
      logic [17:0] a;
      k = int'($urandom_range(1, 0));
      a = 18'($urandom_range(7, 0));
      run_txn(k, 1'($urandom), a, $urandom,
              1'($urandom));
    end
    chk_idle(0, "end0");
    chk_idle(1, "end1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
